pipe_control_unit: RTL and testbench
====================================

# pipe_control_unit

Parametrised pipelined control unit for the 16-bit TSC datapath: decodes the ID-stage instruction into a control bundle and registers it into ID/EX. Adds hazard detection (load-use or full RAW stall), redirect flush, memory-stall freeze, halt drain and a retired-issue counter. It sits between the IF/ID latch and the ID/EX latch and drives the PC and pipeline-latch enables.

## Interface
- `REG_ADDR_W`, 2: register index width.
- `PIPE_DEPTH`, 5: stages. Halt drain length is PIPE_DEPTH-2 cycles.
- `FORWARDING`, 1: 1 stalls on load-use only; 0 stalls on any RAW against EX or MEM.
- `NUM_INST_W`, 16: issued-instruction counter width.

Ports:
- `clk`  in  1  clock; every register updates on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `id_valid`  in  1  the IF/ID latch holds a real instruction.
- `opcode`  in  4  ID-stage opcode.
- `func_code`  in  6  ID-stage function code.
- `rs`, `rt`  in  REG_ADDR_W  ID-stage source registers.
- `ex_reg_write`, `ex_mem_read`  in  1  status of the instruction in EX.
- `ex_dest`  in  REG_ADDR_W  destination register of the instruction in EX.
- `mem_reg_write`  in  1  register-write flag of the instruction in MEM.
- `mem_dest`  in  REG_ADDR_W  destination register of the instruction in MEM.
- `ex_redirect`  in  1  EX resolved a taken branch, mispredict or jump.
- `mem_busy`  in  1  instruction or data memory not ready.
- `ex_ctrl`  out  bundle  registered control bundle for EX. Fields: `valid`, `branch`, `alu_src`, `mem_read`, `mem_write`, `mem_to_reg`, `pc_to_reg`, `reg_write`, `wwd`, `is_halt`, `reg_dst[1:0]`, `pc_src[1:0]`, `alu_op[3:0]`.
- `pc_write`, `ifid_write`, `ifid_flush`  out  1  PC and IF/ID latch control.
- `halt`  out  1  registered; sticky once the processor is halted.
- `num_inst`  out  NUM_INST_W  count of issued instructions.

## Operation
- **Decode** (TSC ISA):
  - Branch: opcodes 0–3.
  - ALU-immediate: opcodes 4–6.
  - LWD: 7. SWD: 8. JMP: 9. JAL: 10.
  - R-type: opcode 15. Within R-type: func 0–7 is ALU, 25 JPR, 26 JRL, 28 WWD, 29 HLT.
  - Any other encoding decodes to an all-zero bundle with `valid` set (a NOP).
- **Field encodings:**
  - `reg_dst`: 00 rd, 01 rt, 10 $2.
  - `pc_src`: 00 pc+1, 01 branch target, 10 imm, 11 rs.
  - `alu_op`: R-type ALU uses {0, func[2:0]}; opcode 5 gives 3; opcode 6 gives 8; WWD, JPR and JRL give 9; everything else gives 0.
  - `alu_src` = not R-type.
  - `reg_write` = R-ALU, ALU-imm, LWD, JAL or JRL.
- **Register use:**
  - `use_rs` = branch, ALU-imm, LWD, SWD, R-ALU, JPR, JRL, WWD.
  - `use_rt` = R-ALU, opcodes 0–1, SWD.
- **Hazard (`hz`):** asserted when `id_valid` is high and any of the following holds:
  - a used source equals `ex_dest` with `ex_reg_write` high, and either `ex_mem_read` is high or FORWARDING is 0;
  - FORWARDING is 0 and a used source equals `mem_dest` with `mem_reg_write` high.
- **Priority, per cycle:** reset > `mem_busy` > `ex_redirect` > `hz` > normal.
  - `mem_busy`: `pc_write`=`ifid_write`=0, `ex_ctrl` holds, no counting.
  - `ex_redirect`: `ifid_flush`=1, `pc_write`=1, `ex_ctrl` loads a bubble (all zero).
  - `hz`: `pc_write`=`ifid_write`=0, `ex_ctrl` loads a bubble.
  - Normal: `ex_ctrl` loads the decoded bundle (a bubble if `id_valid`=0), and `num_inst` increments if `id_valid`.
- **State machine** (`RUN`, `DRAIN`, `HALTED`):
  - `RUN` → `DRAIN` when HLT issues normally; load `drain_cnt` = PIPE_DEPTH-2.
  - In `DRAIN`: `pc_write`=`ifid_write`=0 and `ex_ctrl` loads bubbles. `drain_cnt` decrements on every cycle without `mem_busy`. Go to `HALTED` on the cycle the count is 1 and decrements.
  - `ex_redirect` in `DRAIN` means the HLT was on a wrong path: flush as above and return to `RUN`.
  - In `HALTED`: `halt`=1, every enable is 0 and `ex_ctrl` is a bubble. Only reset leaves this state.

## Timing
- Reset values: `ex_ctrl`=0, `num_inst`=0, `halt`=0, state=`RUN`, `drain_cnt`=0.
- While `reset_n`=0: `pc_write`, `ifid_write` and `ifid_flush` are 0.
- Decode latency is 1 cycle: an instruction in ID at cycle N appears on `ex_ctrl` after edge N+1.
- `pc_write`, `ifid_write` and `ifid_flush` are combinational from the current inputs and state.
- `halt` rises on the edge that enters `HALTED`.
- `num_inst` wraps modulo 2^NUM_INST_W; HLT itself counts.
- Reset asserted mid-drain or mid-stall clears everything asynchronously. The first cycle after release behaves as `RUN`.

## Structure
- Package `pipe_ctrl_pkg` holds:
  - opcode and function-code constants;
  - the `ctrl_bundle_t` packed struct;
  - the `pc_src` and `reg_dst` localparams;
  - the `alu_op` codes;
  - the state enum.
- Sub-module `inst_decoder`: purely combinational; maps opcode and func_code to `ctrl_bundle_t`, `use_rs` and `use_rt`.

## Test plan
- Reset release followed by ADD (op 15, func 0): `ex_ctrl` = {`valid`, `reg_write`, `reg_dst`=00, `alu_op`=0, `alu_src`=0} one cycle later; `num_inst`=1.
- LWD writing $1 in EX with ADD reading rs=$1 in ID, FORWARDING=1: exactly 1 bubble, `pc_write`=0 for 1 cycle, then ADD issues.
- FORWARDING=0, ADI writing $2 in MEM with SWD using rt=$2: stall for 1 cycle.
- `ex_redirect` together with `hz`: `ifid_flush`=1, `pc_write`=1, bubble issued, `num_inst` unchanged.
- HLT with PIPE_DEPTH=5 and one `mem_busy` cycle during drain: `halt` rises 4 cycles after issue and stays high. A second test applies `ex_redirect` mid-drain: return to `RUN` with `halt`=0.
- NUM_INST_W=4 with 17 issues: `num_inst` reads 1. Asserting `reset_n` low mid-stall: all outputs read 0 immediately.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the TSC pipeline control unit: ISA constants, the ID/EX
// control bundle layout and the control FSM states.
package pipe_ctrl_pkg;

  localparam logic [3:0] OP_BNE   = 4'd0;
  localparam logic [3:0] OP_BEQ   = 4'd1;
  localparam logic [3:0] OP_BGZ   = 4'd2;
  localparam logic [3:0] OP_BLZ   = 4'd3;
  localparam logic [3:0] OP_ADI   = 4'd4;
  localparam logic [3:0] OP_ORI   = 4'd5;
  localparam logic [3:0] OP_LHI   = 4'd6;
  localparam logic [3:0] OP_LWD   = 4'd7;
  localparam logic [3:0] OP_SWD   = 4'd8;
  localparam logic [3:0] OP_JMP   = 4'd9;
  localparam logic [3:0] OP_JAL   = 4'd10;
  localparam logic [3:0] OP_RTYPE = 4'd15;

  localparam logic [5:0] FN_JPR = 6'd25;
  localparam logic [5:0] FN_JRL = 6'd26;
  localparam logic [5:0] FN_WWD = 6'd28;
  localparam logic [5:0] FN_HLT = 6'd29;

  localparam logic [1:0] RD_RD = 2'b00;
  localparam logic [1:0] RD_RT = 2'b01;
  localparam logic [1:0] RD_R2 = 2'b10;

  localparam logic [1:0] PC_NEXT   = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_IMM    = 2'b10;
  localparam logic [1:0] PC_RS     = 2'b11;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_LHI  = 4'd8;
  localparam logic [3:0] ALU_PASS = 4'd9;

  typedef struct packed {
    logic       valid;
    logic       branch;
    logic       alu_src;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       pc_to_reg;
    logic       reg_write;
    logic       wwd;
    logic       is_halt;
    logic [1:0] reg_dst;
    logic [1:0] pc_src;
    logic [3:0] alu_op;
  } ctrl_bundle_t;

  typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_HALTED} state_t;

  // Per-cycle action chosen by the priority logic; drives both enables and state.
  typedef enum logic [2:0] {
    ACT_HOLD, ACT_FLUSH, ACT_STALL, ACT_ISSUE, ACT_DRAIN, ACT_IDLE
  } act_t;

endpackage

// File: rtl/pipe_control_unit_decoder.sv
// Combinational TSC instruction decoder: opcode/func to control bundle and
// source-register usage flags for hazard detection.
module inst_decoder
  import pipe_ctrl_pkg::*;
(
  input  logic [3:0]   opcode,
  input  logic [5:0]   func_code,
  output ctrl_bundle_t ctrl,
  output logic         use_rs,
  output logic         use_rt
);

  always_comb begin
    ctrl         = '0;
    ctrl.valid   = 1'b1;
    ctrl.reg_dst = RD_RD;
    ctrl.pc_src  = PC_NEXT;
    ctrl.alu_op  = ALU_ADD;
    use_rs       = 1'b0;
    use_rt       = 1'b0;
    case (opcode)
      OP_BNE, OP_BEQ, OP_BGZ, OP_BLZ: begin
        ctrl.branch  = 1'b1;
        ctrl.alu_src = 1'b1;
        ctrl.pc_src  = PC_BRANCH;
        use_rs       = 1'b1;
        use_rt       = (opcode == OP_BNE) || (opcode == OP_BEQ);
      end
      OP_ADI, OP_ORI, OP_LHI: begin
        ctrl.alu_src   = 1'b1;
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = RD_RT;
        use_rs         = 1'b1;
        if (opcode == OP_ORI)      ctrl.alu_op = ALU_OR;
        else if (opcode == OP_LHI) ctrl.alu_op = ALU_LHI;
      end
      OP_LWD: begin
        ctrl.alu_src    = 1'b1;
        ctrl.mem_read   = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = RD_RT;
        use_rs          = 1'b1;
      end
      OP_SWD: begin
        ctrl.alu_src   = 1'b1;
        ctrl.mem_write = 1'b1;
        use_rs         = 1'b1;
        use_rt         = 1'b1;
      end
      OP_JMP: begin
        ctrl.alu_src = 1'b1;
        ctrl.pc_src  = PC_IMM;
      end
      OP_JAL: begin
        ctrl.alu_src   = 1'b1;
        ctrl.pc_src    = PC_IMM;
        ctrl.pc_to_reg = 1'b1;
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = RD_R2;
      end
      OP_RTYPE: begin
        if (func_code[5:3] == 3'b000) begin
          ctrl.reg_write = 1'b1;
          ctrl.alu_op    = {1'b0, func_code[2:0]};
          use_rs         = 1'b1;
          use_rt         = 1'b1;
        end else begin
          case (func_code)
            FN_JPR: begin
              ctrl.pc_src = PC_RS;
              ctrl.alu_op = ALU_PASS;
              use_rs      = 1'b1;
            end
            FN_JRL: begin
              ctrl.pc_src    = PC_RS;
              ctrl.pc_to_reg = 1'b1;
              ctrl.reg_write = 1'b1;
              ctrl.reg_dst   = RD_R2;
              ctrl.alu_op    = ALU_PASS;
              use_rs         = 1'b1;
            end
            FN_WWD: begin
              ctrl.wwd    = 1'b1;
              ctrl.alu_op = ALU_PASS;
              use_rs      = 1'b1;
            end
            FN_HLT: ctrl.is_halt = 1'b1;
            default: ;
          endcase
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/pipe_control_unit.sv
// ID-stage pipeline control: decode into ID/EX, hazard stall, redirect flush,
// memory freeze, halt drain and issued-instruction counting.
module pipe_control_unit
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = 2,
  parameter int PIPE_DEPTH = 5,
  parameter int FORWARDING = 1,
  parameter int NUM_INST_W = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  id_valid,
  input  logic [3:0]            opcode,
  input  logic [5:0]            func_code,
  input  logic [REG_ADDR_W-1:0] rs,
  input  logic [REG_ADDR_W-1:0] rt,
  input  logic                  ex_reg_write,
  input  logic                  ex_mem_read,
  input  logic [REG_ADDR_W-1:0] ex_dest,
  input  logic                  mem_reg_write,
  input  logic [REG_ADDR_W-1:0] mem_dest,
  input  logic                  ex_redirect,
  input  logic                  mem_busy,
  output ctrl_bundle_t          ex_ctrl,
  output logic                  pc_write,
  output logic                  ifid_write,
  output logic                  ifid_flush,
  output logic                  halt,
  output logic [NUM_INST_W-1:0] num_inst
);

  localparam int CNT_W = $clog2(PIPE_DEPTH + 1);
  localparam logic [CNT_W-1:0] DRAIN_LEN = CNT_W'(PIPE_DEPTH - 2);

  ctrl_bundle_t     dec_ctrl_p0;
  logic             use_rs;
  logic             use_rt;
  logic             ex_hit;
  logic             mem_hit;
  logic             hz;
  state_t           state_q;
  logic [CNT_W-1:0] drain_cnt;
  act_t             act;

  inst_decoder u_dec (
    .opcode    (opcode),
    .func_code (func_code),
    .ctrl      (dec_ctrl_p0),
    .use_rs    (use_rs),
    .use_rt    (use_rt)
  );

  assign ex_hit  = ex_reg_write  && ((use_rs && (rs == ex_dest))  || (use_rt && (rt == ex_dest)));
  assign mem_hit = mem_reg_write && ((use_rs && (rs == mem_dest)) || (use_rt && (rt == mem_dest)));
  assign hz = id_valid && ((ex_hit && (ex_mem_read || (FORWARDING == 0)))
                           || ((FORWARDING == 0) && mem_hit));

  always_comb begin
    act        = ACT_IDLE;
    pc_write   = 1'b0;
    ifid_write = 1'b0;
    ifid_flush = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (mem_busy)         act = ACT_HOLD;
        else if (ex_redirect) act = ACT_FLUSH;
        else if (hz)          act = ACT_STALL;
        else                  act = ACT_ISSUE;
      end
      ST_DRAIN: begin
        if (mem_busy)         act = ACT_HOLD;
        else if (ex_redirect) act = ACT_FLUSH;
        else                  act = ACT_DRAIN;
      end
      default: act = ACT_IDLE;
    endcase
    if (reset_n) begin
      pc_write   = (act == ACT_FLUSH) || (act == ACT_ISSUE);
      ifid_write = (act == ACT_FLUSH) || (act == ACT_ISSUE);
      ifid_flush = (act == ACT_FLUSH);
    end
  end

  // ID -> EX boundary
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_RUN;
      drain_cnt <= '0;
      halt      <= 1'b0;
      ex_ctrl   <= '0;
      num_inst  <= '0;
    end else begin
      case (act)
        ACT_HOLD: ;
        ACT_FLUSH: begin
          ex_ctrl   <= '0;
          state_q   <= ST_RUN;
          drain_cnt <= '0;
        end
        ACT_STALL: ex_ctrl <= '0;
        ACT_ISSUE: begin
          ex_ctrl <= id_valid ? dec_ctrl_p0 : '0;
          if (id_valid) begin
            num_inst <= num_inst + NUM_INST_W'(1);
            if (dec_ctrl_p0.is_halt) begin
              state_q   <= ST_DRAIN;
              drain_cnt <= DRAIN_LEN;
            end
          end
        end
        ACT_DRAIN: begin
          ex_ctrl   <= '0;
          drain_cnt <= drain_cnt - CNT_W'(1);
          if (drain_cnt == CNT_W'(1)) begin
            state_q <= ST_HALTED;
            halt    <= 1'b1;
          end
        end
        default: ex_ctrl <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_control_unit.sv
// Directed bench for pipe_control_unit: decode/stall table plus drain, redirect,
// counter-wrap and asynchronous-reset sequences across three parameterisations.
module tb_pipe_control_unit;
  import pipe_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       id_valid;
  logic [3:0] opcode;
  logic [5:0] func_code;
  logic [1:0] rs, rt, ex_dest, mem_dest;
  logic       ex_reg_write, ex_mem_read, mem_reg_write, ex_redirect, mem_busy;

  ctrl_bundle_t a_ctrl, b_ctrl, c_ctrl;
  logic a_pcw, a_ifw, a_fl, a_halt;
  logic b_pcw, b_ifw, b_fl, b_halt;
  logic c_pcw, c_ifw, c_fl, c_halt;
  logic [15:0] a_num, b_num;
  logic [3:0]  c_num;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pipe_control_unit #(.FORWARDING(1)) dut_a (
    .clk(clk), .reset_n(reset_n), .id_valid(id_valid), .opcode(opcode),
    .func_code(func_code), .rs(rs), .rt(rt), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .ex_dest(ex_dest), .mem_reg_write(mem_reg_write),
    .mem_dest(mem_dest), .ex_redirect(ex_redirect), .mem_busy(mem_busy),
    .ex_ctrl(a_ctrl), .pc_write(a_pcw), .ifid_write(a_ifw), .ifid_flush(a_fl),
    .halt(a_halt), .num_inst(a_num));

  pipe_control_unit #(.FORWARDING(0)) dut_b (
    .clk(clk), .reset_n(reset_n), .id_valid(id_valid), .opcode(opcode),
    .func_code(func_code), .rs(rs), .rt(rt), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .ex_dest(ex_dest), .mem_reg_write(mem_reg_write),
    .mem_dest(mem_dest), .ex_redirect(ex_redirect), .mem_busy(mem_busy),
    .ex_ctrl(b_ctrl), .pc_write(b_pcw), .ifid_write(b_ifw), .ifid_flush(b_fl),
    .halt(b_halt), .num_inst(b_num));

  pipe_control_unit #(.NUM_INST_W(4)) dut_c (
    .clk(clk), .reset_n(reset_n), .id_valid(id_valid), .opcode(opcode),
    .func_code(func_code), .rs(rs), .rt(rt), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .ex_dest(ex_dest), .mem_reg_write(mem_reg_write),
    .mem_dest(mem_dest), .ex_redirect(ex_redirect), .mem_busy(mem_busy),
    .ex_ctrl(c_ctrl), .pc_write(c_pcw), .ifid_write(c_ifw), .ifid_flush(c_fl),
    .halt(c_halt), .num_inst(c_num));

  typedef struct {
    logic        v;
    logic [3:0]  op;
    logic [5:0]  fn;
    logic [1:0]  rs, rt;
    logic        exw, exr;
    logic [1:0]  exd;
    logic        memw;
    logic [1:0]  memd;
    logic        redir, busy;
    logic [2:0]  en;
    logic [17:0] ctrl;
    logic        halt;
    logic [15:0] num;
  } vec_t;

  vec_t tbl[$];

  // Bundle bit order: valid,branch,alu_src,mem_read,mem_write,mem_to_reg,
  // pc_to_reg,reg_write,wwd,is_halt,reg_dst,pc_src,alu_op
  function automatic logic [17:0] cb(input logic v, br, asrc, mr, mw, m2r, p2r, rw, w, h,
                                     input logic [1:0] rd, ps, input logic [3:0] aop);
    return {v, br, asrc, mr, mw, m2r, p2r, rw, w, h, rd, ps, aop};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", nm, act, exp);
    end
  endtask

  task automatic clr();
    id_valid = 1'b0; opcode = 4'd0; func_code = 6'd0; rs = 2'd0; rt = 2'd0;
    ex_reg_write = 1'b0; ex_mem_read = 1'b0; ex_dest = 2'd0;
    mem_reg_write = 1'b0; mem_dest = 2'd0; ex_redirect = 1'b0; mem_busy = 1'b0;
  endtask

  task automatic inst(input logic v, input logic [3:0] op, input logic [5:0] fn,
                      input logic [1:0] s, input logic [1:0] t);
    id_valid = v; opcode = op; func_code = fn; rs = s; rt = t;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    clr();
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  task automatic drive(input vec_t t);
    inst(t.v, t.op, t.fn, t.rs, t.rt);
    ex_reg_write = t.exw; ex_mem_read = t.exr; ex_dest = t.exd;
    mem_reg_write = t.memw; mem_dest = t.memd;
    ex_redirect = t.redir; mem_busy = t.busy;
  endtask

  logic [17:0] c_add, c_jmp, c_hlt, c_swd;

  initial begin
    c_add = cb(1,0,0,0,0,0,0,1,0,0,2'b00,2'b00,4'd0);
    c_jmp = cb(1,0,1,0,0,0,0,0,0,0,2'b00,2'b10,4'd0);
    c_hlt = cb(1,0,0,0,0,0,0,0,0,1,2'b00,2'b00,4'd0);
    c_swd = cb(1,0,1,0,1,0,0,0,0,0,2'b00,2'b00,4'd0);

    //            v  op     fn     rs    rt   exw exr exd  mw  md  rdr bsy en      ctrl                                           h  num
    tbl.push_back('{1, 4'd15, 6'd0,  2'd1, 2'd2, 0, 0, 2'd0, 0, 2'd0, 0, 0, 3'b110, c_add, 0, 16'd1});
    tbl.push_back('{1, 4'd5,  6'd0,  2'd0, 2'd1, 0, 0, 2'd0, 0, 2'd0, 0, 0, 3'b110, cb(1,0,1,0,0,0,0,1,0,0,2'b01,2'b00,4'd3), 0, 16'd2});
    tbl.push_back('{1, 4'd6,  6'd0,  2'd0, 2'd1, 0, 0, 2'd0, 0, 2'd0, 0, 0, 3'b110, cb(1,0,1,0,0,0,0,1,0,0,2'b01,2'b00,4'd8), 0, 16'd3});
    tbl.push_back('{1, 4'd7,  6'd0,  2'd0, 2'd1, 0, 0, 2'd0, 0, 2'd0, 0, 0, 3'b110, cb(1,0,1,1,0,1,0,1,0,0,2'b01,2'b00,4'd0), 0, 16'd4});
    tbl.push_back('{1, 4'd8,  6'd0,  2'd0, 2'd3, 1, 0, 2'd3, 0, 2'd0, 0, 0, 3'b110, c_swd, 0, 16'd5});
    tbl.push_back('{1, 4'd1,  6'd0,  2'd0, 2'd1, 0, 0, 2'd0, 0, 2'd0, 0, 0, 3'b110, cb(1,1,1,0,0,0,0,0,0,0,2'b00,2'b01,4'd0), 0, 16'd6});
    tbl.push_back('{1, 4'd10, 6'd0,  2'd0, 2'd0, 0, 0, 2'd0, 0, 2'd0, 0, 0, 3'b110, cb(1,0,1,0,0,0,1,1,0,0,2'b10,2'b10,4'd0), 0, 16'd7});
    tbl.push_back('{1, 4'd9,  6'd0,  2'd0, 2'd0, 0, 0, 2'd0, 0, 2'd0, 0, 0, 3'b110, c_jmp, 0, 16'd8});
    tbl.push_back('{1, 4'd15, 6'd26, 2'd2, 2'd0, 0, 0, 2'd0, 0, 2'd0, 0, 0, 3'b110, cb(1,0,0,0,0,0,1,1,0,0,2'b10,2'b11,4'd9), 0, 16'd9});
    tbl.push_back('{1, 4'd15, 6'd28, 2'd1, 2'd0, 0, 0, 2'd0, 0, 2'd0, 0, 0, 3'b110, cb(1,0,0,0,0,0,0,0,1,0,2'b00,2'b00,4'd9), 0, 16'd10});
    tbl.push_back('{1, 4'd15, 6'd6,  2'd1, 2'd3, 0, 0, 2'd0, 0, 2'd0, 0, 0, 3'b110, cb(1,0,0,0,0,0,0,1,0,0,2'b00,2'b00,4'd6), 0, 16'd11});
    tbl.push_back('{1, 4'd12, 6'd0,  2'd0, 2'd0, 0, 0, 2'd0, 0, 2'd0, 0, 0, 3'b110, 18'h20000, 0, 16'd12});
    tbl.push_back('{0, 4'd15, 6'd0,  2'd1, 2'd2, 0, 0, 2'd0, 0, 2'd0, 0, 0, 3'b110, 18'h00000, 0, 16'd12});
    tbl.push_back('{1, 4'd15, 6'd0,  2'd1, 2'd2, 1, 1, 2'd1, 0, 2'd0, 0, 0, 3'b000, 18'h00000, 0, 16'd12});
    tbl.push_back('{1, 4'd15, 6'd0,  2'd1, 2'd2, 0, 0, 2'd0, 1, 2'd1, 0, 0, 3'b110, c_add, 0, 16'd13});
    tbl.push_back('{1, 4'd15, 6'd0,  2'd0, 2'd2, 1, 1, 2'd2, 0, 2'd0, 0, 0, 3'b000, 18'h00000, 0, 16'd13});
    tbl.push_back('{1, 4'd9,  6'd0,  2'd0, 2'd0, 1, 1, 2'd0, 0, 2'd0, 0, 0, 3'b110, c_jmp, 0, 16'd14});
    tbl.push_back('{1, 4'd15, 6'd0,  2'd1, 2'd2, 0, 0, 2'd0, 0, 2'd0, 0, 1, 3'b000, c_jmp, 0, 16'd14});
    tbl.push_back('{1, 4'd15, 6'd0,  2'd1, 2'd2, 1, 1, 2'd1, 0, 2'd0, 1, 0, 3'b111, 18'h00000, 0, 16'd14});
    tbl.push_back('{1, 4'd15, 6'd0,  2'd1, 2'd2, 0, 0, 2'd0, 0, 2'd0, 0, 0, 3'b110, c_add, 0, 16'd15});
    tbl.push_back('{1, 4'd9,  6'd0,  2'd0, 2'd0, 0, 0, 2'd0, 0, 2'd0, 1, 1, 3'b000, c_add, 0, 16'd15});
    tbl.push_back('{1, 4'd2,  6'd0,  2'd0, 2'd3, 1, 1, 2'd3, 0, 2'd0, 0, 0, 3'b110, cb(1,1,1,0,0,0,0,0,0,0,2'b00,2'b01,4'd0), 0, 16'd16});
    tbl.push_back('{1, 4'd15, 6'd25, 2'd2, 2'd0, 0, 0, 2'd0, 0, 2'd0, 0, 0, 3'b110, cb(1,0,0,0,0,0,0,0,0,0,2'b00,2'b11,4'd9), 0, 16'd17});

    // Reset state, with a decodable instruction present so the enables must be gated
    clr();
    reset_n = 1'b0;
    inst(1, OP_RTYPE, 6'd0, 2'd1, 2'd2);
    #2;
    chk("rst.en", 32'({a_pcw, a_ifw, a_fl}), 32'd0);
    chk("rst.ctrl", 32'(a_ctrl), 32'd0);
    chk("rst.num", 32'(a_num), 32'd0);
    chk("rst.halt", 32'(a_halt), 32'd0);
    tick();
    tick();
    reset_n = 1'b1;

    foreach (tbl[i]) begin
      drive(tbl[i]);
      @(negedge clk);
      chk($sformatf("vec%0d.en", i), 32'({a_pcw, a_ifw, a_fl}), 32'(tbl[i].en));
      tick();
      chk($sformatf("vec%0d.ctrl", i), 32'(a_ctrl), 32'(tbl[i].ctrl));
      chk($sformatf("vec%0d.num", i), 32'(a_num), 32'(tbl[i].num));
      chk($sformatf("vec%0d.halt", i), 32'(a_halt), 32'(tbl[i].halt));
    end

    // No forwarding: ADI in MEM writing $2 stalls SWD reading rt=$2 for one cycle
    do_reset();
    inst(1, OP_SWD, 6'd0, 2'd0, 2'd2);
    mem_reg_write = 1'b1; mem_dest = 2'd2;
    @(negedge clk);
    chk("nofwd.mem.pcw", 32'(b_pcw), 32'd0);
    chk("fwd.mem.pcw", 32'(a_pcw), 32'd1);
    tick();
    chk("nofwd.mem.bubble", 32'(b_ctrl), 32'd0);
    chk("nofwd.mem.num", 32'(b_num), 32'd0);
    mem_reg_write = 1'b0;
    @(negedge clk);
    chk("nofwd.release.pcw", 32'(b_pcw), 32'd1);
    tick();
    chk("nofwd.release.ctrl", 32'(b_ctrl), 32'(c_swd));
    chk("nofwd.release.num", 32'(b_num), 32'd1);
    inst(1, OP_RTYPE, 6'd0, 2'd3, 2'd0);
    ex_reg_write = 1'b1; ex_dest = 2'd3;
    @(negedge clk);
    chk("nofwd.ex.pcw", 32'(b_pcw), 32'd0);
    chk("fwd.ex.pcw", 32'(a_pcw), 32'd1);

    // HLT drain with one memory-busy cycle: halt rises on the 4th edge after issue
    do_reset();
    inst(1, OP_RTYPE, FN_HLT, 2'd0, 2'd0);
    @(negedge clk);
    chk("hlt.issue.en", 32'({a_pcw, a_ifw, a_fl}), 32'b110);
    tick();
    chk("hlt.issue.ctrl", 32'(a_ctrl), 32'(c_hlt));
    chk("hlt.issue.num", 32'(a_num), 32'd1);
    inst(1, OP_RTYPE, 6'd0, 2'd1, 2'd2);
    for (int k = 1; k <= 4; k++) begin
      mem_busy = (k == 2);
      @(negedge clk);
      chk($sformatf("hlt.drain%0d.en", k), 32'({a_pcw, a_ifw, a_fl}), 32'd0);
      tick();
      chk($sformatf("hlt.drain%0d.halt", k), 32'(a_halt), (k == 4) ? 32'd1 : 32'd0);
    end
    chk("hlt.drain.ctrl", 32'(a_ctrl), 32'd0);
    mem_busy = 1'b0;
    ex_redirect = 1'b1;
    @(negedge clk);
    chk("hlt.halted.en", 32'({a_pcw, a_ifw, a_fl}), 32'd0);
    tick();
    chk("hlt.sticky", 32'(a_halt), 32'd1);
    chk("hlt.halted.num", 32'(a_num), 32'd1);
    ex_redirect = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    chk("hlt.reset.halt", 32'(a_halt), 32'd0);
    tick();

    // Redirect mid-drain returns to RUN
    do_reset();
    inst(1, OP_RTYPE, FN_HLT, 2'd0, 2'd0);
    tick();
    inst(1, OP_RTYPE, 6'd0, 2'd1, 2'd2);
    tick();
    ex_redirect = 1'b1;
    @(negedge clk);
    chk("wrongpath.en", 32'({a_pcw, a_ifw, a_fl}), 32'b111);
    tick();
    chk("wrongpath.ctrl", 32'(a_ctrl), 32'd0);
    chk("wrongpath.halt", 32'(a_halt), 32'd0);
    ex_redirect = 1'b0;
    @(negedge clk);
    chk("wrongpath.run.en", 32'({a_pcw, a_ifw, a_fl}), 32'b110);
    tick();
    chk("wrongpath.run.ctrl", 32'(a_ctrl), 32'(c_add));
    chk("wrongpath.run.num", 32'(a_num), 32'd2);
    id_valid = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    chk("wrongpath.nohalt", 32'(a_halt), 32'd0);

    // Counter wraps modulo 2^4 on the narrow instance
    do_reset();
    inst(1, OP_RTYPE, 6'd0, 2'd1, 2'd2);
    for (int k = 0; k < 17; k++) tick();
    chk("wrap.num4", 32'(c_num), 32'd1);
    chk("wrap.num16", 32'(a_num), 32'd17);

    // Asynchronous reset in the middle of a memory stall
    do_reset();
    inst(1, OP_RTYPE, 6'd0, 2'd1, 2'd2);
    tick();
    chk("arst.pre.ctrl", 32'(a_ctrl), 32'(c_add));
    mem_busy = 1'b1;
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst.ctrl", 32'(a_ctrl), 32'd0);
    chk("arst.num", 32'(a_num), 32'd0);
    chk("arst.halt", 32'(a_halt), 32'd0);
    chk("arst.en", 32'({a_pcw, a_ifw, a_fl}), 32'd0);
    tick();
    mem_busy = 1'b0;
    reset_n = 1'b1;
    @(negedge clk);
    chk("arst.after.en", 32'({a_pcw, a_ifw, a_fl}), 32'b110);
    tick();
    chk("arst.after.ctrl", 32'(a_ctrl), 32'(c_add));
    chk("arst.after.num", 32'(a_num), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
